// File: rtl/unsigned_div_ctrl_pkg.sv
// rtl/unsigned_div_ctrl_pkg.sv - state encodings and step-counter width helper for the divider controller
package unsigned_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_CAPT = 2'd2
    } div_state_t;

    // Counter must hold N-1; a 1-bit counter is the floor even for N <= 2.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unsigned_div_ctrl.sv
// rtl/unsigned_div_ctrl.sv - sequencing controller for the restoring unsigned divider datapath
module unsigned_div_ctrl
    import unsigned_div_ctrl_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_dividend,
    input  logic [M-1:0] in_divisor,
    output logic [N-1:0] dp_word1,
    output logic [M-1:0] dp_word2,
    output logic         dp_load,
    output logic         dp_shift,
    output logic         dp_subshift,
    input  logic         dp_lt,
    input  logic [N-1:0] dp_quotient,
    input  logic [M-1:0] dp_remainder,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_quotient,
    output logic [M-1:0] res_remainder,
    output logic         res_dz,
    output logic         busy
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    div_state_t    r_state;
    div_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    logic          w_div_zero;
    logic          r_res_valid;
    logic [N-1:0]  r_res_quotient;
    logic [M-1:0]  r_res_remainder;
    logic          r_res_dz;

    assign dp_word1      = in_dividend;
    assign dp_word2      = in_divisor;
    assign w_div_zero    = (in_divisor == '0);
    // A new operand pair may enter in the same cycle the held result is consumed.
    assign in_ready      = (r_state == ST_IDLE) && (!r_res_valid || res_ready);
    assign w_accept      = in_valid && in_ready;
    assign busy          = (r_state == ST_ITER) || (r_state == ST_CAPT);
    assign res_valid     = r_res_valid;
    assign res_quotient  = r_res_quotient;
    assign res_remainder = r_res_remainder;
    assign res_dz        = r_res_dz;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath strobes; a zero divisor never loads the datapath.
    always_comb begin
        w_next      = r_state;
        dp_load     = 1'b0;
        dp_shift    = 1'b0;
        dp_subshift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_div_zero) begin
                    dp_load = 1'b1;
                    w_next  = ST_ITER;
                end
            end
            ST_ITER: begin
                dp_shift    = dp_lt;
                dp_subshift = !dp_lt;
                if (r_cnt == '0) begin
                    w_next = ST_CAPT;
                end
            end
            ST_CAPT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Step counter: loaded with N-1 on a real accept, counts down through ITER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && w_accept && !w_div_zero) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == ST_ITER && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result registers: setting (capture or divide-by-zero) wins over consumption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_valid     <= 1'b0;
            r_res_quotient  <= '0;
            r_res_remainder <= '0;
            r_res_dz        <= 1'b0;
        end else if (r_state == ST_CAPT) begin
            r_res_valid     <= 1'b1;
            r_res_quotient  <= dp_quotient;
            r_res_remainder <= dp_remainder;
            r_res_dz        <= 1'b0;
        end else if (w_accept && w_div_zero) begin
            r_res_valid     <= 1'b1;
            r_res_quotient  <= '1;
            r_res_remainder <= '0;
            r_res_dz        <= 1'b1;
        end else if (r_res_valid && res_ready) begin
            r_res_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_unsigned_div_ctrl.sv
// tb/tb_unsigned_div_ctrl.sv - self-checking bench for unsigned_div_ctrl with a behavioural datapath
module tb_unsigned_div_ctrl;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_dividend;
    logic [M-1:0] in_divisor;
    logic [N-1:0] dp_word1;
    logic [M-1:0] dp_word2;
    logic         dp_load;
    logic         dp_shift;
    logic         dp_subshift;
    logic         dp_lt;
    logic [N-1:0] dp_quotient;
    logic [M-1:0] dp_remainder;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_quotient;
    logic [M-1:0] res_remainder;
    logic         res_dz;
    logic         busy;

    unsigned_div_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .dp_word1(dp_word1), .dp_word2(dp_word2),
        .dp_load(dp_load), .dp_shift(dp_shift), .dp_subshift(dp_subshift),
        .dp_lt(dp_lt), .dp_quotient(dp_quotient), .dp_remainder(dp_remainder),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_quotient(res_quotient), .res_remainder(res_remainder),
        .res_dz(res_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Restoring divider datapath driven by the controller's strobes.
    logic [M-1:0] dpa;
    logic [M-1:0] dpd;
    logic [N-1:0] dpq;
    logic [M:0]   trial;
    assign trial        = {dpa, dpq[N-1]};
    assign dp_lt        = trial < {1'b0, dpd};
    assign dp_quotient  = dpq;
    assign dp_remainder = dpa;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dpa <= '0; dpd <= '0; dpq <= '0;
        end else if (dp_load) begin
            dpa <= '0; dpq <= dp_word1; dpd <= dp_word2;
        end else if (dp_shift) begin
            dpa <= trial[M-1:0]; dpq <= {dpq[N-2:0], 1'b0};
        end else if (dp_subshift) begin
            dpa <= M'(trial - {1'b0, dpd}); dpq <= {dpq[N-2:0], 1'b1};
        end
    end

    // Reference model: plain division, cycles-to-result count, held result.
    int           m_busy;
    logic         m_valid;
    logic [N-1:0] m_q, m_pq;
    logic [M-1:0] m_r, m_pr;
    logic         m_dz;
    logic         m_in_ready;
    assign m_in_ready = (m_busy == 0) && (!m_valid || res_ready);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_valid <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
            m_pq <= '0; m_pr <= '0;
        end else begin
            if (m_valid && res_ready) m_valid <= 1'b0;
            if (in_valid && m_in_ready) begin
                if (in_divisor == '0) begin
                    m_valid <= 1'b1; m_q <= '1; m_r <= '0; m_dz <= 1'b1;
                end else begin
                    m_busy <= N + 1;
                    m_pq   <= in_dividend / N'(in_divisor);
                    m_pr   <= M'(in_dividend % N'(in_divisor));
                end
            end else if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1; m_q <= m_pq; m_r <= m_pr; m_dz <= 1'b0;
                end
            end
        end
    end

    int n_loads    = 0;
    int op_strobes = 0;
    int op_shifts  = 0;

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_strobes", 32'({dp_load, dp_shift, dp_subshift}), 32'd0);
            chk("rst_res_q", 32'(res_quotient), 32'd0);
            chk("rst_res_r", 32'(res_remainder), 32'd0);
            chk("rst_res_dz", 32'(res_dz), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_in_ready));
            chk("busy", 32'(busy), 32'(m_busy != 0));
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("res_q", 32'(res_quotient), 32'(m_q));
                chk("res_r", 32'(res_remainder), 32'(m_r));
                chk("res_dz", 32'(res_dz), 32'(m_dz));
            end
            chk("dp_load", 32'(dp_load), 32'(in_valid && m_in_ready && in_divisor != '0));
            chk("dp_word1", 32'(dp_word1), 32'(in_dividend));
            chk("dp_word2", 32'(dp_word2), 32'(in_divisor));
            if (dp_load) begin
                n_loads++;
                op_strobes = 0;
                op_shifts  = 0;
            end
            if (m_busy >= 2) begin
                chk("dp_shift", 32'(dp_shift), 32'(dp_lt));
                chk("dp_subshift", 32'(dp_subshift), 32'(!dp_lt));
                if (dp_shift || dp_subshift) op_strobes++;
                if (dp_shift) op_shifts++;
            end else begin
                chk("no_step_strobe", 32'({dp_shift, dp_subshift}), 32'd0);
            end
            if (m_busy == 1) chk("step_count", 32'(op_strobes), 32'(N));
        end
    end

    int c0;

    // Offer an operand pair once in_ready is seen; call at posedge+1.
    task automatic start_op(input logic [N-1:0] a, input logic [M-1:0] b);
        int tries = 0;
        #1;
        while (!in_ready && tries < 40) begin
            @(posedge clk); #2;
            tries++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd1, 32'd0);
        end else begin
            in_dividend = a;
            in_divisor  = b;
            in_valid    = 1'b1;
            c0          = cyc;
            @(posedge clk); #1;
            in_valid    = 1'b0;
        end
    endtask

    task automatic wait_res(output int lat);
        int tries = 0;
        lat = -1;
        while (tries < 40) begin
            @(negedge clk);
            if (res_valid) begin
                lat = cyc - c0;
                break;
            end
            tries++;
        end
        if (lat < 0) chk("res_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_result(input string name, input logic [N-1:0] q, input logic [M-1:0] r,
                              input logic dz, input int lat, input int exp_lat);
        chk({name, "_q"}, 32'(res_quotient), 32'(q));
        chk({name, "_r"}, 32'(res_remainder), 32'(r));
        chk({name, "_dz"}, 32'(res_dz), 32'(dz));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_state"}, 32'({res_valid, busy, res_dz, dp_load, dp_shift, dp_subshift}), 32'd0);
        chk({name, "_q"}, 32'(res_quotient), 32'd0);
        chk({name, "_r"}, 32'(res_remainder), 32'd0);
    endtask

    initial begin
        int lat;
        int loads0;
        reset = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        in_dividend = '0; in_divisor = '0;
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        start_op(8'd200, 4'd7);
        wait_res(lat);
        chk_result("d200_7", 8'd28, 4'd4, 1'b0, lat, 10);
        chk("d200_7_steps", 32'(op_strobes), 32'd8);
        @(posedge clk); #1;

        start_op(8'd255, 4'd1);
        wait_res(lat);
        chk_result("d255_1", 8'd255, 4'd0, 1'b0, lat, 10);
        @(posedge clk); #1;

        start_op(8'd5, 4'd9);
        wait_res(lat);
        chk_result("d5_9", 8'd0, 4'd5, 1'b0, lat, 10);
        chk("d5_9_shifts", 32'(op_shifts), 32'd8);
        @(posedge clk); #1;

        loads0 = n_loads;
        start_op(8'd100, 4'd0);
        wait_res(lat);
        chk_result("d100_0", 8'hFF, 4'd0, 1'b1, lat, 1);
        chk("d100_0_no_load", 32'(n_loads), 32'(loads0));
        @(posedge clk); #1;

        // Backpressure, then same-cycle take and accept.
        res_ready = 1'b0;
        start_op(8'd200, 4'd7);
        wait_res(lat);
        chk_result("bp", 8'd28, 4'd4, 1'b0, lat, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({res_valid, res_quotient, res_remainder}), 32'({1'b1, 8'd28, 4'd4}));
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        start_op(8'd37, 4'd5);
        chk("bp_same_cycle_accept", 32'(c0), 32'(cyc - 1));
        wait_res(lat);
        chk_result("d37_5", 8'd7, 4'd2, 1'b0, lat, 10);
        @(posedge clk); #1;

        // Reset in the fourth ITER cycle.
        start_op(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_op(8'd13, 4'd3);
        wait_res(lat);
        chk_result("d13_3", 8'd4, 4'd1, 1'b0, lat, 10);
        @(posedge clk); #1;

        // Every non-zero-divisor operand pair.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_op(N'(a), M'(b));
                wait_res(lat);
                chk("sweep_q", 32'(res_quotient), 32'(a / b));
                chk("sweep_r", 32'(res_remainder), 32'(a % b));
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unsigned_div_ctrl.md
# unsigned_div_ctrl

Sequencing controller for the team's restoring unsigned divider datapath (N-bit dividend, M-bit divisor, one quotient bit per cycle). It accepts operands over a valid/ready handshake and loads the datapath. It then issues exactly N shift/subtract-shift steps steered by the datapath's less-than flag, and captures the quotient and remainder into a held result port with its own valid/ready handshake. Divide-by-zero is detected at acceptance and bypasses the datapath.

## Interface
- N, default 8: dividend/quotient width.
- M, default 4: divisor/remainder width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller accepts operands this cycle.
- in_dividend  in  N  dividend.
- in_divisor  in  M  divisor.
- dp_word1  out  N  to datapath, equals in_dividend (combinational pass-through).
- dp_word2  out  M  to datapath, equals in_divisor.
- dp_load  out  1  datapath load strobe.
- dp_shift  out  1  datapath shift-in-0 strobe.
- dp_subshift  out  1  datapath subtract-and-shift-in-1 strobe.
- dp_lt  in  1  datapath flag: partial remainder < divisor.
- dp_quotient  in  N  datapath quotient.
- dp_remainder  in  M  datapath remainder.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- res_quotient  out  N  registered quotient.
- res_remainder  out  M  registered remainder.
- res_dz  out  1  result is a divide-by-zero.
- busy  out  1  high in ITER or CAPT.

## Operation
- States: IDLE, ITER, CAPT. Reset -> IDLE.
- in_ready = (state==IDLE) && (!res_valid || res_ready). Accept = in_valid && in_ready.
- IDLE, accept, in_divisor != 0: dp_load=1 this cycle; cnt <= N-1; -> ITER.
- IDLE, accept, in_divisor == 0: dp_load=0; res_quotient <= all ones; res_remainder <= 0; res_dz <= 1; res_valid <= 1; stay IDLE.
- ITER: dp_shift = dp_lt, dp_subshift = !dp_lt; exactly one is high every ITER cycle. cnt decrements; at cnt==0 -> CAPT.
- CAPT: no strobes. res_quotient <= dp_quotient; res_remainder <= dp_remainder; res_dz <= 0; res_valid <= 1; -> IDLE.
- res_valid clears on res_valid && res_ready, unless the same edge sets it (CAPT or DZ accept). Set wins.
- Result registers are stable while res_valid && !res_ready.
- dp_load/dp_shift/dp_subshift are mutually exclusive and all low outside the cases above.
- cnt width: clog2(N) bits, minimum 1.

## Timing
- Accept in cycle 0 -> ITER cycles 1..N -> CAPT cycle N+1 -> res_valid high from cycle N+2. For N=8, that is cycle 10.
- Divide-by-zero: res_valid high in cycle 1.
- Throughput: one division per N+2 cycles with res_ready held high. A new accept is allowed in the same cycle the old result is taken.
- in_valid while busy: ignored, in_ready=0. Operands must be held by the producer until accepted.
- Reset at any time, including mid-ITER: state=IDLE, cnt=0, res_valid=0, res_quotient=0, res_remainder=0, res_dz=0, all dp strobes 0, busy=0. The datapath shares the same reset.

## Structure
- Shared package/include: state encodings (IDLE=2'd0, ITER=2'd1, CAPT=2'd2) and the clog2 helper for cnt width.
- Controller is FSM plus counter plus result registers only. An optional integration wrapper, unsigned_div_unit, instantiates this controller and the datapath as its single sub-module, with dp_* wired point-to-point.

## Test plan
- 200 / 7 with res_ready=1 -> res_valid in cycle 10, quotient 28, remainder 4, res_dz=0; exactly 8 shift/subshift strobes.
- 255 / 1 -> quotient 255, remainder 0; 5 / 9 -> quotient 0, remainder 5, all 8 steps are shifts.
- 100 / 0 -> res_valid in cycle 1, quotient 8'hFF, remainder 0, res_dz=1, dp_load never asserted.
- Backpressure: res_ready=0 for 20 cycles after result -> outputs stable, in_ready=0. Raise res_ready together with in_valid (37/5) -> same-cycle accept, next result quotient 7, remainder 2.
- Reset asserted in cycle 4 of ITER -> all outputs at reset values immediately. Subsequent 13/3 -> quotient 4, remainder 1.
- Random sweep over all 256x15 non-zero operand pairs -> quotient/remainder match the reference model; busy high for exactly N+1 cycles per op.
